apb_slave_regfile: RTL and testbench



---
 rtl/apb_slave_regfile_if.sv | 31 +++
 rtl/apb_slave_regfile.sv | 167 ++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
// APB bridge-to-completer signal bundle for apb_slave_regfile.
// Pstrb exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_regfile_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  Pstrb;
`endif
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
`ifdef APB_SLV_PSTRB_EN
        output Pstrb,
`endif
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
`ifdef APB_SLV_PSTRB_EN
        input  Pstrb,
`endif
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers, programmable wait states, reg 0 exported
// as ctrl_out and the top index returning status_in. Byte strobes enabled by APB_SLV_PSTRB_EN.
module apb_slave_regfile #(
    parameter int unsigned NREG        = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SEL_IDX     = 0
) (
    input  logic                clk,
    input  logic                rst,
    apb_slave_regfile_if.slave  bus,
    output logic [31:0]         ctrl_out,
    input  logic [31:0]         status_in
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    // Index NREG-1 is the status input, so only NREG-1 registers are stored.
    logic [31:0] regs_q [NREG-1];
    logic [31:0] regs_d [NREG-1];
    logic [31:0] wmask;

`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  strb_q, strb_d;
    assign wmask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
`else
    assign wmask = '1;
`endif

    logic sel;
    logic setup_go, abort, step, complete;
    assign sel      = bus.Pselx[SEL_IDX];
    assign setup_go = (state_q == StIdle) && sel && !bus.Penable;
    assign abort    = (state_q == StAccess) && !sel;
    assign step     = (state_q == StAccess) && sel && bus.Penable && !pready_q;
    assign complete = (state_q == StAccess) && sel && bus.Penable && pready_q;

    // The response is decoded from the live bus in IDLE (zero-wait case) and from the
    // captured setup values during the access phase.
    logic [31:0] rsp_addr;
    logic        rsp_write;
    logic [3:0]  rsp_idx;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    assign rsp_addr  = (state_q == StIdle) ? bus.Paddr : addr_q;
    assign rsp_write = (state_q == StIdle) ? bus.Pwrite : write_q;
    assign rsp_idx   = rsp_addr[5:2];
    assign rsp_err   = (rsp_addr[1:0] != 2'b00) || (rsp_addr[31:6] != '0) ||
                       (32'(rsp_idx) >= NREG) || (rsp_write && (32'(rsp_idx) == NREG - 1));

    always_comb begin
        rsp_rdata = '0;
        if (!rsp_write && !rsp_err) begin
            if (32'(rsp_idx) == NREG - 1) begin
                rsp_rdata = status_in;
            end else begin
                for (int i = 0; i < int'(NREG) - 1; i++) begin
                    if (rsp_idx == 4'(i)) rsp_rdata = regs_q[i];
                end
            end
        end
    end

    // State register, datapath and response flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= '0;
`endif
            for (int i = 0; i < int'(NREG) - 1; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= strb_d;
`endif
            regs_q    <= regs_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (setup_go) state_d = StAccess;
            StAccess: if (abort || complete) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        pready_d  = pready_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        regs_d    = regs_q;
`ifdef APB_SLV_PSTRB_EN
        strb_d    = strb_q;
`endif
        if (setup_go) begin
            addr_d   = bus.Paddr;
            wdata_d  = bus.Pwdata;
            write_d  = bus.Pwrite;
`ifdef APB_SLV_PSTRB_EN
            strb_d   = bus.Pstrb;
`endif
            cnt_d    = 4'(WAIT_CYCLES);
            pready_d = (WAIT_CYCLES == 0);
            if (WAIT_CYCLES == 0) begin
                prdata_d  = rsp_rdata;
                pslverr_d = rsp_err;
            end
        end else if (step) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                pready_d  = 1'b1;
                prdata_d  = rsp_rdata;
                pslverr_d = rsp_err;
            end
        end else if (complete) begin
            if (write_q && !rsp_err) begin
                for (int i = 0; i < int'(NREG) - 1; i++) begin
                    if (rsp_idx == 4'(i)) regs_d[i] = (regs_q[i] & ~wmask) | (wdata_q & wmask);
                end
            end
            pready_d  = 1'b0;
            prdata_d  = '0;
            pslverr_d = 1'b0;
        end else if (abort) begin
            pready_d  = 1'b0;
            prdata_d  = '0;
            pslverr_d = 1'b0;
        end
    end

    assign bus.Prdata  = prdata_q;
    assign bus.Pready  = pready_q;
    assign bus.Pslverr = pslverr_q;
    assign ctrl_out    = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: dut0 has one wait state on Pselx[0], dut1 has none on Pselx[1].
module tb_apb_slave_regfile;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  pselx;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] status0, status1;
    logic [31:0] ctrl0, ctrl1;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb;
`endif

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus1 ();

    assign bus0.Pselx   = pselx;
    assign bus0.Penable = penable;
    assign bus0.Pwrite  = pwrite;
    assign bus0.Paddr   = paddr;
    assign bus0.Pwdata  = pwdata;
    assign bus1.Pselx   = pselx;
    assign bus1.Penable = penable;
    assign bus1.Pwrite  = pwrite;
    assign bus1.Paddr   = paddr;
    assign bus1.Pwdata  = pwdata;
`ifdef APB_SLV_PSTRB_EN
    assign bus0.Pstrb   = pstrb;
    assign bus1.Pstrb   = pstrb;
`endif

    apb_slave_regfile #(.NREG(8), .WAIT_CYCLES(1), .SEL_IDX(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .ctrl_out(ctrl0), .status_in(status0)
    );
    apb_slave_regfile #(.NREG(8), .WAIT_CYCLES(0), .SEL_IDX(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .ctrl_out(ctrl1), .status_in(status1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] x_rd;
    logic [31:0] x_ctrl_rdy;
    logic        x_err;
    int          x_waits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? bus0.Pready : bus1.Pready;
    endfunction

    function automatic logic [31:0] rdata(input int s);
        return (s == 0) ? bus0.Prdata : bus1.Prdata;
    endfunction

    function automatic logic slverr(input int s);
        return (s == 0) ? bus0.Pslverr : bus1.Pslverr;
    endfunction

    task automatic idle();
        pselx   = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    // One transfer: setup cycle, access cycles until Pready, completing edge.
    task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd);
        pselx   = 3'(1 << s);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        x_waits = 0;
        while (!rdy(s) && x_waits < 20) begin
            @(posedge clk); #1;
            x_waits++;
        end
        x_rd       = rdata(s);
        x_err      = slverr(s);
        x_ctrl_rdy = (s == 0) ? ctrl0 : ctrl1;
        @(posedge clk); #1;
        check("wait_states", 32'(x_waits), (s == 0) ? 32'd1 : 32'd0);
        check("pready_one_cycle", 32'(rdy(s)), 32'd0);
        check("prdata_after", rdata(s), 32'd0);
    endtask

    initial begin
        pselx   = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        status0 = '0;
        status1 = 32'hA5A5_A5A5;
`ifdef APB_SLV_PSTRB_EN
        pstrb   = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready", 32'(bus0.Pready), 32'd0);
        check("rst_prdata", bus0.Prdata, 32'd0);
        check("rst_pslverr", 32'(bus0.Pslverr), 32'd0);
        check("rst_ctrl0", ctrl0, 32'd0);
        check("rst_ctrl1", ctrl1, 32'd0);
        rst = 1'b1;
        idle();

        // Write reg 0, ctrl_out follows only after the completing edge
        xfer(0, 1'b1, 32'h00, 32'hDEAD_BEEF);
        check("t1_err", 32'(x_err), 32'd0);
        check("t1_ctrl_at_ready", x_ctrl_rdy, 32'd0);
        check("t1_ctrl_after", ctrl0, 32'hDEAD_BEEF);
        check("t1_other_slave", ctrl1, 32'd0);

        xfer(0, 1'b0, 32'h00, 32'h0);
        check("t2_rd", x_rd, 32'hDEAD_BEEF);
        check("t2_err", 32'(x_err), 32'd0);

        // Status register
        status0 = 32'h1234_5678;
        xfer(0, 1'b0, 32'h1C, 32'h0);
        check("t3_status_rd", x_rd, 32'h1234_5678);
        xfer(0, 1'b1, 32'h1C, 32'h1);
        check("t3_status_wr_err", 32'(x_err), 32'd1);
        check("t3_status_wr_rd", x_rd, 32'd0);
        status0 = 32'h0BAD_F00D;
        xfer(0, 1'b0, 32'h1C, 32'h0);
        check("t3_status_resample", x_rd, 32'h0BAD_F00D);
        check("t3_status_rd_err", 32'(x_err), 32'd0);

        // Error responses, none may alias onto reg 0
        xfer(0, 1'b1, 32'h22, 32'h5A5A_5A5A);
        check("t4_misalign_err", 32'(x_err), 32'd1);
        xfer(0, 1'b1, 32'h40, 32'h5A5A_5A5A);
        check("t4_range_err", 32'(x_err), 32'd1);
        check("t4_range_rd", x_rd, 32'd0);
        xfer(0, 1'b1, 32'h01, 32'h5A5A_5A5A);
        check("t4_byte_err", 32'(x_err), 32'd1);
        xfer(0, 1'b1, 32'h1000_0000, 32'h5A5A_5A5A);
        check("t4_high_err", 32'(x_err), 32'd1);
        xfer(0, 1'b0, 32'h20, 32'h0);
        check("t4_rd_range_err", 32'(x_err), 32'd1);
        check("t4_rd_range_data", x_rd, 32'd0);
        check("t4_ctrl_kept", ctrl0, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h00, 32'h0);
        check("t4_reg0_kept", x_rd, 32'hDEAD_BEEF);

        // Penable without setup is ignored
        pselx   = 3'b001;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("nosetup_pready", 32'(bus0.Pready), 32'd0);
        idle();

        // Deselect during access aborts without commit
        pselx   = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        pselx   = 3'b000;
        @(posedge clk); #1;
        check("abort_pready", 32'(bus0.Pready), 32'd0);
        idle();
        xfer(0, 1'b0, 32'h08, 32'h0);
        check("abort_no_commit", x_rd, 32'd0);

        // Address/data/direction changes during access are ignored
        pselx   = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h11;
        @(posedge clk); #1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h10;
        pwdata  = 32'h22;
        @(posedge clk); #1;
        check("late_change_ready", 32'(bus0.Pready), 32'd1);
        check("late_change_err", 32'(bus0.Pslverr), 32'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0C, 32'h0);
        check("late_change_0c", x_rd, 32'h11);
        xfer(0, 1'b0, 32'h10, 32'h0);
        check("late_change_10", x_rd, 32'd0);
        idle();

        // Zero-wait slave, back-to-back transfers
        xfer(1, 1'b1, 32'h04, 32'h1);
        xfer(1, 1'b1, 32'h08, 32'h2);
        xfer(1, 1'b1, 32'h0C, 32'h3);
        xfer(1, 1'b0, 32'h04, 32'h0);
        check("t5_rd04", x_rd, 32'h1);
        xfer(1, 1'b0, 32'h08, 32'h0);
        check("t5_rd08", x_rd, 32'h2);
        xfer(1, 1'b0, 32'h0C, 32'h0);
        check("t5_rd0c", x_rd, 32'h3);
        xfer(1, 1'b0, 32'h1C, 32'h0);
        check("t5_status1", x_rd, 32'hA5A5_A5A5);
        xfer(0, 1'b0, 32'h04, 32'h0);
        check("t5_dut0_untouched", x_rd, 32'd0);
        idle();

        // Reset in the middle of an access with Pready already up
        pselx   = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h0000_FFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_pready", 32'(bus0.Pready), 32'd0);
        check("t6_ctrl_cleared", ctrl0, 32'd0);
        check("t6_ctrl1_cleared", ctrl1, 32'd0);
        pselx   = 3'b000;
        penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        xfer(0, 1'b0, 32'h04, 32'h0);
        check("t6_reg04", x_rd, 32'd0);

`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'b0010;
        xfer(0, 1'b1, 32'h04, 32'hAABB_CCDD);
        check("strb_err", 32'(x_err), 32'd0);
        pstrb = 4'b0000;
        xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF);
        check("strb_zero_err", 32'(x_err), 32'd0);
        pstrb = 4'b0000;
        xfer(0, 1'b0, 32'h04, 32'h0);
        check("strb_rd", x_rd, 32'h0000_CC00);
        pstrb = 4'hF;
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
